// File: rtl/seg_scan_if.sv
// Bundle between the display scan controller and whoever supplies digit content.
// The master loads patterns; the slave drives the shared segment bus and anodes.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [7*NUM_DIGITS-1:0] digit_codes;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [6:0]              seg_raw;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_done;
    logic                    update_pending;

    modport master (
        output digit_codes,
        output digit_en,
        output load,
        input  seg_raw,
        input  an_n,
        input  frame_done,
        input  update_pending
    );

    modport slave (
        input  digit_codes,
        input  digit_en,
        input  load,
        output seg_raw,
        output an_n,
        output frame_done,
        output update_pending
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-digit blanking and a
// double-buffered content register that only swaps on frame boundaries.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int MAX_PHASE = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW        = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [IW-1:0]           idx_reg, idx_next;

    logic [7*NUM_DIGITS-1:0] active_codes_reg, shadow_codes_reg;
    logic [NUM_DIGITS-1:0]   active_en_reg, shadow_en_reg;
    logic                    pending_reg;

    logic [6:0]              seg_raw_reg, seg_next;
    logic [NUM_DIGITS-1:0]   an_n_reg, an_next;
    logic                    frame_done_reg, frame_done_next;
    logic                    frame_end;

    logic [6:0]              code_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   digit_on;

    // Sequencer: BLANK then SHOW per digit, counter restarts on every phase change.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        idx_next   = idx_reg;
        if (state_reg == ST_BLANK) begin
            if (cnt_reg == BLANK_LAST) begin
                state_next = ST_SHOW;
                cnt_next   = '0;
            end
        end else if (cnt_reg == SHOW_LAST) begin
            state_next = ST_BLANK;
            cnt_next   = '0;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    // frame_end marks the cycle currently being shown as the last of the frame;
    // the registered pulse is derived from the position we are about to enter.
    assign frame_end       = (state_reg == ST_SHOW) && (cnt_reg == SHOW_LAST) && (idx_reg == IDX_LAST);
    assign frame_done_next = (state_next == ST_SHOW) && (cnt_next == SHOW_LAST) && (idx_next == IDX_LAST);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign code_arr[gi] = active_codes_reg[7*gi +: 7];
            assign digit_on[gi] = (state_next == ST_SHOW) && (idx_next == IW'(gi)) && active_en_reg[gi];
            assign an_next[gi]  = ~digit_on[gi];
        end
    endgenerate

    // At most one digit_on bit is set, so an OR-merge acts as the segment mux.
    always_comb begin
        seg_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_on[i]) begin
                seg_next = seg_next | code_arr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= ST_BLANK;
            cnt_reg          <= '0;
            idx_reg          <= '0;
            active_codes_reg <= '0;
            shadow_codes_reg <= '0;
            active_en_reg    <= '0;
            shadow_en_reg    <= '0;
            pending_reg      <= 1'b0;
            seg_raw_reg      <= '0;
            an_n_reg         <= '1;
            frame_done_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            seg_raw_reg    <= seg_next;
            an_n_reg       <= an_next;
            frame_done_reg <= frame_done_next;

            // A load coinciding with the boundary bypasses the shadow so it is
            // never held back a whole frame.
            if (frame_end) begin
                if (bus.load) begin
                    active_codes_reg <= bus.digit_codes;
                    active_en_reg    <= bus.digit_en;
                    shadow_codes_reg <= bus.digit_codes;
                    shadow_en_reg    <= bus.digit_en;
                end else if (pending_reg) begin
                    active_codes_reg <= shadow_codes_reg;
                    active_en_reg    <= shadow_en_reg;
                end
                pending_reg <= 1'b0;
            end else if (bus.load) begin
                shadow_codes_reg <= bus.digit_codes;
                shadow_en_reg    <= bus.digit_en;
                pending_reg      <= 1'b1;
            end
        end
    end

    assign bus.seg_raw        = seg_raw_reg;
    assign bus.an_n           = an_n_reg;
    assign bus.frame_done     = frame_done_reg;
    assign bus.update_pending = pending_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a position-arithmetic display model checked every cycle,
// plus directed loads/resets with hand-computed literal expectations.
module tb_seg_scan_ctrl;
    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = BC + RD;
    localparam int FRAME = ND * SLOT;

    localparam logic [27:0] CODES_A = {7'h06, 7'h5B, 7'h4F, 7'h66};
    localparam logic [27:0] CODES_C = {7'h7F, 7'h3F, 7'h6D, 7'h07};
    localparam logic [27:0] CODES_D = {7'h01, 7'h02, 7'h03, 7'h04};
    localparam logic [27:0] CODES_E = {7'h11, 7'h22, 7'h33, 7'h44};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model state: t is the cycle number since reset release.
    int              t = 0;
    bit              model_valid = 1'b0;
    logic [6:0]      m_codes [ND];
    logic [6:0]      s_codes [ND];
    logic [ND-1:0]   m_en;
    logic [ND-1:0]   s_en;
    logic            m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            t           <= 0;
            model_valid <= 1'b1;
            m_pend      <= 1'b0;
            m_en        <= '0;
            s_en        <= '0;
            for (int i = 0; i < ND; i++) begin
                m_codes[i] <= '0;
                s_codes[i] <= '0;
            end
        end else if (model_valid) begin
            t <= t + 1;
            if ((t % FRAME) == FRAME - 1) begin
                if (bus.load) begin
                    for (int i = 0; i < ND; i++) begin
                        m_codes[i] <= bus.digit_codes[7*i +: 7];
                        s_codes[i] <= bus.digit_codes[7*i +: 7];
                    end
                    m_en <= bus.digit_en;
                    s_en <= bus.digit_en;
                end else if (m_pend) begin
                    for (int i = 0; i < ND; i++) begin
                        m_codes[i] <= s_codes[i];
                    end
                    m_en <= s_en;
                end
                m_pend <= 1'b0;
            end else if (bus.load) begin
                for (int i = 0; i < ND; i++) begin
                    s_codes[i] <= bus.digit_codes[7*i +: 7];
                end
                s_en   <= bus.digit_en;
                m_pend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int            pos;
        int            d;
        int            ph;
        logic [ND-1:0] e_an;
        logic [6:0]    e_seg;
        if (model_valid) begin
            pos   = t % FRAME;
            d     = pos / SLOT;
            ph    = pos % SLOT;
            e_an  = '1;
            e_seg = '0;
            if (ph >= BC && m_en[d]) begin
                e_an[d] = 1'b0;
                e_seg   = m_codes[d];
            end
            chk("cyc_an_n",   32'(bus.an_n),           32'(e_an));
            chk("cyc_seg",    32'(bus.seg_raw),        32'(e_seg));
            chk("cyc_fdone",  32'(bus.frame_done),     32'(pos == FRAME - 1));
            chk("cyc_pend",   32'(bus.update_pending), 32'(m_pend));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int n);
        int budget;
        budget = 0;
        while (t != n && budget < 500) begin
            tick();
            budget++;
        end
        if (t != n) begin
            checks++;
            errors++;
            $display("FAIL go_to actual=%0d required=%0d", t, n);
        end
    endtask

    task automatic do_load(input logic [27:0] codes, input logic [3:0] en);
        bus.digit_codes = codes;
        bus.digit_en    = en;
        bus.load        = 1'b1;
        tick();
        bus.load        = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    task automatic lit(input string name, input logic [3:0] an, input logic [6:0] seg);
        chk({name, "_an"},  32'(bus.an_n),    32'(an));
        chk({name, "_seg"}, 32'(bus.seg_raw), 32'(seg));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "timeout");
    end

    initial begin
        bus.load        = 1'b0;
        bus.digit_codes = '0;
        bus.digit_en    = '0;
        do_reset(2);

        // Idle after reset: dark display, frame pulses at 23 and 47.
        lit("reset", 4'hF, 7'h00);
        chk("reset_fd",   32'(bus.frame_done),     32'd0);
        chk("reset_pend", 32'(bus.update_pending), 32'd0);
        go_to(23); chk("idle_fd23", 32'(bus.frame_done), 32'd1);
        go_to(24); chk("idle_fd24", 32'(bus.frame_done), 32'd0);
        go_to(47); chk("idle_fd47", 32'(bus.frame_done), 32'd1);
        lit("idle47", 4'hF, 7'h00);

        // First load at cycle 5, visible from frame 2.
        do_reset(1);
        go_to(5);
        do_load(CODES_A, 4'b1111);
        chk("load_pend6",  32'(bus.update_pending), 32'd1);
        go_to(23); chk("load_pend23", 32'(bus.update_pending), 32'd1);
        go_to(24); chk("load_pend24", 32'(bus.update_pending), 32'd0);
        go_to(26); lit("f2_d0_26", 4'b1110, 7'h66);
        go_to(29); lit("f2_d0_29", 4'b1110, 7'h66);
        go_to(30); lit("f2_blank30", 4'b1111, 7'h00);
        go_to(32); lit("f2_d1", 4'b1101, 7'h4F);
        go_to(38); lit("f2_d2", 4'b1011, 7'h5B);
        go_to(44); lit("f2_d3", 4'b0111, 7'h06);
        go_to(47); chk("f2_fd47", 32'(bus.frame_done), 32'd1);

        // Disable digit 2 mid-frame: current frame untouched, next frame dark slot.
        go_to(50);
        do_load(CODES_A, 4'b1011);
        go_to(62); lit("f3_d2_unchanged", 4'b1011, 7'h5B);
        go_to(86); lit("f4_d2_dark", 4'b1111, 7'h00);
        go_to(92); lit("f4_d3", 4'b0111, 7'h06);
        go_to(95); chk("f4_fd95", 32'(bus.frame_done), 32'd1);

        // Load on the frame_done cycle bypasses the shadow.
        do_load(CODES_C, 4'b1111);
        chk("bypass_pend", 32'(bus.update_pending), 32'd0);
        go_to(98); lit("bypass_d0", 4'b1110, 7'h07);

        // Two loads in one frame: last wins, current frame unchanged.
        go_to(99);
        do_load(CODES_D, 4'b1111);
        go_to(104); lit("dbl_cur_d1", 4'b1101, 7'h6D);
        go_to(106);
        do_load(CODES_E, 4'b1111);
        chk("dbl_pend", 32'(bus.update_pending), 32'd1);
        go_to(122); lit("dbl_d0", 4'b1110, 7'h44);
        go_to(128); lit("dbl_d1", 4'b1101, 7'h33);

        // Reset during digit 2 SHOW aborts and clears content.
        go_to(135);
        lit("pre_rst_d2", 4'b1011, 7'h22);
        rst_n = 1'b0;
        tick();
        lit("midrst", 4'hF, 7'h00);
        chk("midrst_fd",   32'(bus.frame_done),     32'd0);
        chk("midrst_pend", 32'(bus.update_pending), 32'd0);
        rst_n = 1'b1;
        go_to(23); chk("post_rst_fd", 32'(bus.frame_done), 32'd1);
        go_to(26); lit("post_rst_dark", 4'hF, 7'h00);
        go_to(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
